// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB 1.1 receive bit-timing stage.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RUN  = 2'd2
    } rx_timer_state_t;

    localparam int USB_STUFF_LEN     = 6;
    localparam int USB_BITS_PER_BYTE = 8;

endpackage

// File: rtl/usb_rx_stuff_tracker.sv
// Bit-stuffing tracker: counts consecutive decoded ones and flags the
// next sample as a stuffed bit once a run of USB_STUFF_LEN ones is seen.
// The run count deliberately survives byte boundaries; only clear resets it.
module usb_rx_stuff_tracker
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic sample_tick,
    input  logic d_orig,
    input  logic clear,
    output logic is_stuff
);

    localparam int ONES_W = $clog2(USB_STUFF_LEN + 1);
    localparam logic [ONES_W-1:0] ONES_LIMIT = ONES_W'(USB_STUFF_LEN);

    logic [ONES_W-1:0] ones_q, ones_d, ones_inc;
    logic              stuff_pend_q, stuff_pend_d;

    // Next-state for the ones run counter and the stuffed-bit flag
    always_comb begin
        ones_d       = ones_q;
        stuff_pend_d = stuff_pend_q;
        ones_inc     = ones_q + 1'b1;
        if (clear) begin
            ones_d       = '0;
            stuff_pend_d = 1'b0;
        end else if (sample_tick) begin
            if (stuff_pend_q) begin
                // This sample was the stuffed bit; the run starts over.
                ones_d       = '0;
                stuff_pend_d = 1'b0;
            end else if (d_orig) begin
                if (ones_inc == ONES_LIMIT) begin
                    ones_d       = '0;
                    stuff_pend_d = 1'b1;
                end else begin
                    ones_d = ones_inc;
                end
            end else begin
                ones_d = '0;
            end
        end
    end

    // Tracker registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q       <= '0;
            stuff_pend_q <= 1'b0;
        end else begin
            ones_q       <= ones_d;
            stuff_pend_q <= stuff_pend_d;
        end
    end

    assign is_stuff = stuff_pend_q;

endmodule

// File: rtl/usb_rx_timer.sv
// USB 1.1 receive bit-timing stage: recovers bit timing from D+ edges,
// issues one shift_enable per data bit at the mid-bit sample point,
// drops stuffed bits and flags each completed byte.
// Optional feature macro: USB_RX_STUFF_ERR_EN (stuff_err pulse on a
// stuffed bit decoded as 1; otherwise stuff_err is tied low).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no packet; all counters held at zero, outputs low
// HUNT  | packet started, waiting for the first edge to lock phase
// RUN   | phase locked; sampling once per bit, resync on every edge
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);

    localparam int PHASE_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W   = $clog2(USB_BITS_PER_BYTE);
    localparam logic [PHASE_W-1:0] PHASE_ONE    = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_WRAP   = PHASE_W'(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_PT);
    localparam logic [BIT_W-1:0]   BIT_LAST     = BIT_W'(USB_BITS_PER_BYTE - 1);

    rx_timer_state_t    state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               shift_enable_q, shift_enable_d;
    logic               byte_wrap_q, byte_wrap_d;
    logic               byte_received_q, byte_received_d;
    logic               sample_tick;
    logic               is_stuff;
    logic               tracker_clear;

    // An edge landing exactly on the sample point wins: the sample is skipped
    assign sample_tick   = (state_q == RUN) && (phase_q == PHASE_SAMPLE) && !d_edge;
    assign tracker_clear = !rcving || (state_q == IDLE);

    usb_rx_stuff_tracker u_stuff_tracker (
        .clk         (clk),
        .n_rst       (n_rst),
        .sample_tick (sample_tick),
        .d_orig      (d_orig),
        .clear       (tracker_clear),
        .is_stuff    (is_stuff)
    );

    // FSM next-state, phase/bit counters and output pulse generation
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        bit_cnt_d       = bit_cnt_q;
        shift_enable_d  = 1'b0;
        byte_wrap_d     = 1'b0;
        byte_received_d = byte_wrap_q;
        case (state_q)
            IDLE: begin
                phase_d   = '0;
                bit_cnt_d = '0;
                if (rcving) begin
                    state_d = HUNT;
                end
            end
            HUNT: begin
                if (d_edge) begin
                    state_d = RUN;
                    phase_d = PHASE_ONE;
                end
            end
            RUN: begin
                if (d_edge || (phase_q == PHASE_WRAP)) begin
                    phase_d = PHASE_ONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
                if (sample_tick && !is_stuff) begin
                    shift_enable_d = 1'b1;
                    bit_cnt_d      = bit_cnt_q + 1'b1;
                    byte_wrap_d    = (bit_cnt_q == BIT_LAST);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Losing rcving aborts the packet, including any pulse in flight.
        if (!rcving) begin
            state_d         = IDLE;
            phase_d         = '0;
            bit_cnt_d       = '0;
            shift_enable_d  = 1'b0;
            byte_wrap_d     = 1'b0;
            byte_received_d = 1'b0;
        end
    end

    // FSM and counter registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            bit_cnt_q       <= '0;
            shift_enable_q  <= 1'b0;
            byte_wrap_q     <= 1'b0;
            byte_received_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_enable_q  <= shift_enable_d;
            byte_wrap_q     <= byte_wrap_d;
            byte_received_q <= byte_received_d;
        end
    end

    assign shift_enable  = shift_enable_q;
    assign byte_received = byte_received_q;

`ifdef USB_RX_STUFF_ERR_EN
    logic stuff_err_q, stuff_err_d;

    // A stuffed bit must decode as 0; a 1 there is reported, timing is unaffected
    always_comb begin
        stuff_err_d = rcving && sample_tick && is_stuff && d_orig;
    end

    // Stuff error pulse register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuff_err_q <= 1'b0;
        end else begin
            stuff_err_q <= stuff_err_d;
        end
    end

    assign stuff_err = stuff_err_q;
`else
    assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed testbench for usb_rx_timer (CLKS_PER_BIT=8, SAMPLE_PT=4).
module tb_usb_rx_timer;

`ifdef USB_RX_STUFF_ERR_EN
    localparam bit STUFF_ERR_EN = 1'b1;
`else
    localparam bit STUFF_ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    logic rcving;
    logic d_edge;
    logic d_orig;
    logic shift_enable;
    logic byte_received;
    logic stuff_err;

    int errors = 0;
    int checks = 0;

    logic obs_se, obs_br, obs_err;

    usb_rx_timer #(.CLKS_PER_BIT(8), .SAMPLE_PT(4)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rcving        (rcving),
        .d_edge        (d_edge),
        .d_orig        (d_orig),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .stuff_err     (stuff_err)
    );

    always #5 clk = ~clk;

    // One cycle: capture outputs of the current cycle, then drive its inputs.
    task automatic step(input logic rcv, input logic edg, input logic dor);
        @(negedge clk);
        obs_se  = shift_enable;
        obs_br  = byte_received;
        obs_err = stuff_err;
        rcving  = rcv;
        d_edge  = edg;
        d_orig  = dor;
    endtask

    task automatic idle_gap();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        n_rst  = 1'b0;
        rcving = 1'b0;
        d_edge = 1'b0;
        d_orig = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (shift_enable !== 1'b0) begin
            errors++; $display("FAIL reset_shift_enable got=%b exp=0", shift_enable);
        end
        checks++;
        if (byte_received !== 1'b0) begin
            errors++; $display("FAIL reset_byte_received got=%b exp=0", byte_received);
        end
        checks++;
        if (stuff_err !== 1'b0) begin
            errors++; $display("FAIL reset_stuff_err got=%b exp=0", stuff_err);
        end
        n_rst = 1'b1;
        idle_gap();
    endtask

    task automatic test_reset_mid_run();
        logic exp_se;
        for (int c = 0; c <= 7; c++) begin
            step(1'b1, c == 2, 1'b0);
            exp_se = (c == 7);
            checks++;
            if (obs_se !== exp_se) begin
                errors++; $display("FAIL rst_pre_shift cycle=%0d got=%b exp=%b", c, obs_se, exp_se);
            end
        end
        #1 n_rst = 1'b0;
        rcving = 1'b0;
        d_edge = 1'b0;
        #1;
        checks++;
        if (shift_enable !== 1'b0) begin
            errors++; $display("FAIL rst_async_shift got=%b exp=0", shift_enable);
        end
        checks++;
        if (byte_received !== 1'b0) begin
            errors++; $display("FAIL rst_async_byte got=%b exp=0", byte_received);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            step(c < 28, c == 20, 1'b0);
            exp_se = (c == 25);
            checks++;
            if (obs_se !== exp_se) begin
                errors++; $display("FAIL rst_post_shift cycle=%0d got=%b exp=%b", c, obs_se, exp_se);
            end
        end
        idle_gap();
    endtask

    task automatic test_two_bytes();
        logic edg, exp_se, exp_br;
        for (int c = 0; c <= 145; c++) begin
            edg    = (c >= 10) && (c <= 130) && ((c - 10) % 8 == 0);
            exp_se = (c >= 15) && (c <= 135) && ((c - 15) % 8 == 0);
            exp_br = (c == 72) || (c == 136);
            step(c < 136, edg, 1'b0);
            checks++;
            if (obs_se !== exp_se) begin
                errors++; $display("FAIL bytes_shift cycle=%0d got=%b exp=%b", c, obs_se, exp_se);
            end
            checks++;
            if (obs_br !== exp_br) begin
                errors++; $display("FAIL bytes_byte_rx cycle=%0d got=%b exp=%b", c, obs_br, exp_br);
            end
        end
        idle_gap();
    endtask

    task automatic test_resync();
        logic edg, exp_se, exp_br;
        for (int c = 0; c <= 72; c++) begin
            edg    = c inside {2, 9, 18, 25, 34, 41, 50, 57};
            exp_se = c inside {7, 14, 23, 30, 39, 46, 55, 62};
            exp_br = (c == 63);
            step(c < 63, edg, 1'b0);
            checks++;
            if (obs_se !== exp_se) begin
                errors++; $display("FAIL resync_shift cycle=%0d got=%b exp=%b", c, obs_se, exp_se);
            end
            checks++;
            if (obs_br !== exp_br) begin
                errors++; $display("FAIL resync_byte_rx cycle=%0d got=%b exp=%b", c, obs_br, exp_br);
            end
        end
        idle_gap();
    endtask

    // stuff_one selects the decoded value of the stuffed bit (sampled at cycle 54)
    task automatic test_stuffing(input logic stuff_one);
        logic edg, dor, exp_se, exp_br, exp_err;
        for (int c = 0; c <= 88; c++) begin
            edg     = (c >= 2) && (c <= 74) && ((c - 2) % 8 == 0);
            dor     = stuff_one ? (c < 56) : (c < 50);
            exp_se  = (c >= 7) && (c <= 79) && ((c - 7) % 8 == 0) && (c != 55);
            exp_br  = (c == 72);
            exp_err = STUFF_ERR_EN && stuff_one && (c == 55);
            step(c < 80, edg, dor);
            checks++;
            if (obs_se !== exp_se) begin
                errors++; $display("FAIL stuff%0d_shift cycle=%0d got=%b exp=%b", stuff_one, c, obs_se, exp_se);
            end
            checks++;
            if (obs_br !== exp_br) begin
                errors++; $display("FAIL stuff%0d_byte_rx cycle=%0d got=%b exp=%b", stuff_one, c, obs_br, exp_br);
            end
            checks++;
            if (obs_err !== exp_err) begin
                errors++; $display("FAIL stuff%0d_err cycle=%0d got=%b exp=%b", stuff_one, c, obs_err, exp_err);
            end
        end
        idle_gap();
    endtask

    task automatic test_abort_restart();
        logic edg, rcv, exp_se, exp_br;
        for (int c = 0; c <= 122; c++) begin
            edg    = ((c >= 2) && (c <= 34) && ((c - 2) % 8 == 0)) ||
                     ((c >= 52) && (c <= 108) && ((c - 52) % 8 == 0));
            rcv    = (c < 40) || ((c >= 50) && (c < 115));
            exp_se = ((c >= 7) && (c <= 39) && ((c - 7) % 8 == 0)) ||
                     ((c >= 57) && (c <= 113) && ((c - 57) % 8 == 0));
            exp_br = (c == 114);
            step(rcv, edg, 1'b0);
            checks++;
            if (obs_se !== exp_se) begin
                errors++; $display("FAIL abort_shift cycle=%0d got=%b exp=%b", c, obs_se, exp_se);
            end
            checks++;
            if (obs_br !== exp_br) begin
                errors++; $display("FAIL abort_byte_rx cycle=%0d got=%b exp=%b", c, obs_br, exp_br);
            end
        end
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_two_bytes();
        test_resync();
        test_stuffing(1'b0);
        test_stuffing(1'b1);
        test_abort_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
